// File: rtl/gshare_branch_predictor.sv
// Fetch-stage direction/target predictor: 2-bit counter table (gshare when GSHARE_EN, else bimodal) plus tagged direct-mapped BTB.
// Latency: prediction is combinational from pc_f (0 cycles); training from execute lands on the next rising clk edge.
// Backpressure: none; a prediction is produced every cycle and every cflow_valid update is accepted.
module gshare_branch_predictor #(
    parameter int         BHT_ENTRIES = 256,
    parameter int         BTB_ENTRIES = 64,
    parameter int         GHR_BITS    = 8,
    parameter logic [1:0] CTR_INIT    = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic [31:0] pc_e,
    input  logic        cflow_valid,
    input  logic        cflow_taken,
    input  logic [31:0] cflow_target
);

    localparam int BI = $clog2(BHT_ENTRIES);
    localparam int TI = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - TI;

    logic [1:0]             bht     [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_vld;
    logic [TW-1:0]          btb_tag [BTB_ENTRIES];
    logic [31:0]            btb_tgt [BTB_ENTRIES];

    logic [BI-1:0] hidx_f;
    logic [BI-1:0] hidx_e;
    logic [TI-1:0] tidx_f;
    logic [TI-1:0] tidx_e;
    logic          btb_hit;
    logic [1:0]    ctr_e;
    logic [1:0]    ctr_nxt;
    logic          unused_bits;

`ifdef GSHARE_EN
    // History is architectural only; fetch and execute both hash with the same committed GHR.
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_nxt;

    assign hidx_f = pc_f[BI+1:2] ^ BI'(ghr);
    assign hidx_e = pc_e[BI+1:2] ^ BI'(ghr);

    generate
        if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_nxt = cflow_taken;
        end else begin : g_ghrn
            assign ghr_nxt = {ghr[GHR_BITS-2:0], cflow_taken};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (cflow_valid) begin
            ghr <= ghr_nxt;
        end
    end

    assign unused_bits = ^pc_e[1:0];
`else
    logic [GHR_BITS-1:0] unused_ghr;

    assign hidx_f      = pc_f[BI+1:2];
    assign hidx_e      = pc_e[BI+1:2];
    assign unused_ghr  = '0;
    assign unused_bits = ^{pc_e[1:0], unused_ghr};
`endif

    assign tidx_f = pc_f[TI+1:2];
    assign tidx_e = pc_e[TI+1:2];

    // Predict path reads pre-edge state only: no bypass from a same-cycle update.
    assign btb_hit     = btb_vld[tidx_f] && (btb_tag[tidx_f] == pc_f[31:TI+2]);
    assign pred_taken  = bht[hidx_f][1] && btb_hit;
    assign pred_target = pred_taken ? btb_tgt[tidx_f] : pc_f + 32'd4;

    assign ctr_e = bht[hidx_e];

    always_comb begin
        ctr_nxt = ctr_e;
        if (cflow_taken) begin
            if (ctr_e != 2'b11) ctr_nxt = ctr_e + 2'd1;
        end else begin
            if (ctr_e != 2'b00) ctr_nxt = ctr_e - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
        end else if (cflow_valid) begin
            bht[hidx_e] <= ctr_nxt;
        end
    end

    // Not-taken resolutions never invalidate an entry; taken ones overwrite unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_vld <= '0;
        end else if (cflow_valid && cflow_taken) begin
            btb_vld[tidx_e] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cflow_valid && cflow_taken) begin
            btb_tag[tidx_e] <= pc_e[31:TI+2];
            btb_tgt[tidx_e] <= cflow_target;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor; the history test is selected by GSHARE_EN, the rest target the default build.
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_f = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pc_e = '0;
    logic        cflow_valid = 1'b0;
    logic        cflow_taken = 1'b0;
    logic [31:0] cflow_target = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gshare_branch_predictor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_f         (pc_f),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .pc_e         (pc_e),
        .cflow_valid  (cflow_valid),
        .cflow_taken  (cflow_taken),
        .cflow_target (cflow_target)
    );

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        cflow_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        @(negedge clk);
        pc_e = pc;
        cflow_taken = tk;
        cflow_target = tgt;
        cflow_valid = 1'b1;
        @(posedge clk);
        #1 cflow_valid = 1'b0;
    endtask

    task automatic probe(input logic [31:0] pc);
        @(negedge clk);
        pc_f = pc;
        #1;
    endtask

    task automatic expect_pred(input string name, input logic exp_tk, input logic [31:0] exp_tgt);
        checks++;
        if (pred_taken !== exp_tk || pred_target !== exp_tgt) begin
            errors++;
            $display("FAIL %s pc_f=%h got taken=%b target=%h want taken=%b target=%h",
                     name, pc_f, pred_taken, pred_target, exp_tk, exp_tgt);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        // Assert reset mid-cycle with a taken update still presented across the next edge.
        @(posedge clk);
        #3;
        pc_e = 32'h100; cflow_taken = 1'b1; cflow_target = 32'h200; cflow_valid = 1'b1;
        pc_f = 32'h100;
        #1 rst_n = 1'b0;
        #1;
        expect_pred("reset_async", 1'b0, 32'h104);
        @(posedge clk);
        #1 cflow_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a <= 32'h3FC; a += 4) begin
            probe(32'(a));
            expect_pred("reset_sweep", 1'b0, 32'(a) + 32'd4);
        end
    endtask

    task automatic test_idle();
        apply_reset();
        @(negedge clk);
        pc_e = 32'h100; cflow_taken = 1'b1; cflow_target = 32'h200; cflow_valid = 1'b0;
        repeat (3) @(posedge clk);
        probe(32'h100);
        expect_pred("idle_no_update", 1'b0, 32'h104);
    endtask

    task automatic test_wrap();
        apply_reset();
        probe(32'hFFFF_FFFC);
        expect_pred("wrap", 1'b0, 32'h0000_0000);
    endtask

`ifdef GSHARE_EN
    task automatic test_history();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            train(32'h40, (i % 2) == 0, 32'h140);
            // From the 9th resolution on, history alternates 0x55/0xAA and two trained counters predict the next outcome.
            if (i >= 8) begin
                probe(32'h40);
                if ((i % 2) == 1) expect_pred("hist_step", 1'b1, 32'h140);
                else              expect_pred("hist_step", 1'b0, 32'h44);
            end
        end
        probe(32'h40);
        expect_pred("hist_final", 1'b1, 32'h140);
    endtask
`else
    task automatic test_saturation();
        apply_reset();
        train(32'h100, 1'b1, 32'h200);
        probe(32'h100);
        expect_pred("sat_first_taken", 1'b1, 32'h200);
        repeat (3) train(32'h100, 1'b1, 32'h200);
        probe(32'h100);
        expect_pred("sat_at_11", 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        probe(32'h100);
        expect_pred("sat_11_to_10", 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        probe(32'h100);
        expect_pred("sat_to_01", 1'b0, 32'h104);
    endtask

    task automatic test_btb_alias();
        apply_reset();
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        probe(32'h100);
        expect_pred("alias_before", 1'b1, 32'h200);
        train(32'h200, 1'b1, 32'h300);
        probe(32'h200);
        expect_pred("alias_new", 1'b1, 32'h300);
        probe(32'h100);
        expect_pred("alias_evicted", 1'b0, 32'h104);
    endtask

    task automatic test_alternate();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            train(32'h40, (i % 2) == 0, 32'h140);
            probe(32'h40);
            if ((i % 2) == 0) expect_pred("alt_step", 1'b1, 32'h140);
            else              expect_pred("alt_step", 1'b0, 32'h44);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        train(32'h80, 1'b1, 32'h180);
        train(32'h80, 1'b0, 32'h0);
        @(negedge clk);
        pc_f = 32'h80;
        pc_e = 32'h80; cflow_taken = 1'b1; cflow_target = 32'h180; cflow_valid = 1'b1;
        #1;
        expect_pred("same_cycle_old", 1'b0, 32'h84);
        @(posedge clk);
        #1 cflow_valid = 1'b0;
        probe(32'h80);
        expect_pred("same_cycle_next", 1'b1, 32'h180);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_idle();
        test_wrap();
`ifdef GSHARE_EN
        test_history();
`else
        test_saturation();
        test_btb_alias();
        test_alternate();
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
